// File: rtl/npu_ofmap_drain_pkg.sv
// Shared parameters and state encoding for the NPU output-feature-map drain.
package npu_ofmap_drain_pkg;

  localparam int unsigned W         = 8;
  localparam int unsigned N         = 2;
  localparam int unsigned BG        = 6;
  localparam int unsigned ACC_W     = 16;
  localparam int unsigned NB_TILE   = 4;
  localparam int unsigned NB_TILEC  = 16;
  localparam int unsigned CLOG2T    = $clog2(NB_TILE);
  localparam int unsigned CLOG2C    = $clog2(NB_TILEC);
  localparam int unsigned ADDR_W    = $clog2(NB_TILE * NB_TILE * NB_TILEC);

  localparam int unsigned CT_W      = CLOG2T + 1;
  localparam int unsigned CC_W      = CLOG2C + 1;
  localparam int unsigned ROW_W     = W * N;
  localparam int unsigned TILE_W    = W * W * N;
  localparam int unsigned ROW_CNT_W = $clog2(W);
  localparam int unsigned QMAX      = (1 << N) - 1;

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, DONE} state_t;

endpackage

// File: rtl/npu_requant.sv
// One-lane requantizer: ReLU, arithmetic shift by BG, saturate to N-bit unsigned.
module npu_requant
  import npu_ofmap_drain_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  output logic [N-1:0]     q_c
);

  localparam int unsigned SH_W = ACC_W - BG;

  logic [SH_W-1:0] sh;

  // Shift is only used for strictly positive inputs, so a plain slice is exact.
  assign sh = acc[ACC_W-1:BG];

  always_comb begin
    q_c = '0;
    if (!acc[ACC_W-1] && (acc != '0)) begin
      if (sh > SH_W'(QMAX)) q_c = N'(QMAX);
      else                  q_c = sh[N-1:0];
    end
  end

endmodule

// File: rtl/npu_ofmap_drain.sv
// Drains PE-array result rows, requantizes and packs each WxW tile into one
// ofmap word written at a tile-linear address.
module npu_ofmap_drain
  import npu_ofmap_drain_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CT_W-1:0]   cfg_tile,
  input  logic [CC_W-1:0]   cfg_tilec,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W*ACC_W-1:0] in_row,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [TILE_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  state_t                 state;
  logic [CT_W-1:0]        cfg_tile_q;
  logic [CC_W-1:0]        cfg_tilec_q;
  logic [ROW_CNT_W-1:0]   row_cnt;
  logic [CLOG2T-1:0]      tx;
  logic [CLOG2T-1:0]      ty;
  logic [CLOG2C-1:0]      tc;

  logic [ROW_W-1:0]       row_q_c;
  logic [ADDR_W-1:0]      addr_c;
  logic                   row_acc_c;
  logic                   row_last_c;
  logic                   tx_last_c;
  logic                   ty_last_c;
  logic                   tc_last_c;

  for (genvar j = 0; j < W; j++) begin : g_lane
    npu_requant u_requant (
      .acc (in_row[j*ACC_W +: ACC_W]),
      .q_c (row_q_c[j*N +: N])
    );
  end

  assign addr_c     = (ADDR_W'(tc) * ADDR_W'(cfg_tile_q) + ADDR_W'(ty)) * ADDR_W'(cfg_tile_q)
                      + ADDR_W'(tx);
  assign row_acc_c  = in_valid & in_ready;
  assign row_last_c = (row_cnt == ROW_CNT_W'(W - 1));
  assign tx_last_c  = (CT_W'(tx) == cfg_tile_q - CT_W'(1));
  assign ty_last_c  = (CT_W'(ty) == cfg_tile_q - CT_W'(1));
  assign tc_last_c  = (CC_W'(tc) == cfg_tilec_q - CC_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cfg_tile_q  <= '0;
      cfg_tilec_q <= '0;
      row_cnt     <= '0;
      tx          <= '0;
      ty          <= '0;
      tc          <= '0;
      in_ready    <= 1'b0;
      wr_valid    <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cfg_tile_q  <= cfg_tile;
            cfg_tilec_q <= cfg_tilec;
            row_cnt     <= '0;
            tx          <= '0;
            ty          <= '0;
            tc          <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b1;
            state       <= COLLECT;
          end
        end

        COLLECT: begin
          if (row_acc_c) begin
            // wr_data doubles as the packing register; it is only valid in EMIT.
            for (int unsigned r = 0; r < W; r++) begin
              if (row_cnt == ROW_CNT_W'(r)) wr_data[r*ROW_W +: ROW_W] <= row_q_c;
            end
            if (row_last_c) begin
              row_cnt  <= '0;
              in_ready <= 1'b0;
              wr_valid <= 1'b1;
              wr_addr  <= addr_c;
              state    <= EMIT;
            end else begin
              row_cnt <= row_cnt + ROW_CNT_W'(1);
            end
          end
        end

        EMIT: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            if (tx_last_c && ty_last_c && tc_last_c) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              if (tx_last_c) begin
                tx <= '0;
                if (ty_last_c) begin
                  ty <= '0;
                  tc <= tc + CLOG2C'(1);
                end else begin
                  ty <= ty + CLOG2T'(1);
                end
              end else begin
                tx <= tx + CLOG2T'(1);
              end
              in_ready <= 1'b1;
              state    <= COLLECT;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_ofmap_drain.sv
// Directed self-checking bench for npu_ofmap_drain.
module tb_npu_ofmap_drain;
  import npu_ofmap_drain_pkg::*;

  logic              clk;
  logic              rst;
  logic              start;
  logic [CT_W-1:0]   cfg_tile;
  logic [CC_W-1:0]   cfg_tilec;
  logic              in_valid;
  logic              in_ready;
  logic [W*ACC_W-1:0] in_row;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [TILE_W-1:0] wr_data;
  logic              busy;
  logic              done;

  int pass_cnt = 0;
  int total_cnt = 0;

  npu_ofmap_drain dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_tile  (cfg_tile),
    .cfg_tilec (cfg_tilec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W*ACC_W-1:0] mk_row(input logic [ACC_W-1:0] lane0);
    logic [W*ACC_W-1:0] r;
    r = '0;
    r[ACC_W-1:0] = lane0;
    return r;
  endfunction

  function automatic logic [TILE_W-1:0] lane0_tile(input logic [N-1:0] q);
    logic [TILE_W-1:0] t;
    t = '0;
    for (int r = 0; r < W; r++) t[r*ROW_W +: N] = q;
    return t;
  endfunction

  // Holds a row valid until accepted; entered and left on a falling edge.
  task automatic drive_row(input logic [W*ACC_W-1:0] row);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_row = row;
    for (int i = 0; i < 64 && !got; i++) begin
      if (in_ready === 1'b1) got = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!got) begin
      total_cnt++;
      $display("FAIL row_accept_timeout: in_ready stayed %b, required 1", in_ready);
    end
  endtask

  task automatic send_rows(input logic [ACC_W-1:0] lane0, input int n);
    for (int i = 0; i < n; i++) drive_row(mk_row(lane0));
  endtask

  task automatic do_start(input logic [CT_W-1:0] t, input logic [CC_W-1:0] c);
    cfg_tile = t;
    cfg_tilec = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_row = mk_row(16'd128);
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({in_ready, wr_valid, busy, done} !== 4'b0000) $display("FAIL reset_ctrl: got %b required 0000", {in_ready, wr_valid, busy, done});
    else pass_cnt++;
    total_cnt++;
    if (wr_addr !== '0) $display("FAIL reset_addr: got %0h required 0", wr_addr);
    else pass_cnt++;
    total_cnt++;
    if (wr_data !== '0) $display("FAIL reset_data: got %h required 0", wr_data);
    else pass_cnt++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL idle_no_accept: in_ready %b required 0", in_ready);
    else pass_cnt++;
    in_valid = 1'b0;
  endtask

  task automatic test_requant();
    logic [ACC_W-1:0] vals [W] = '{16'hFFFB, 16'd0, 16'd63, 16'd64, 16'd191, 16'd192, 16'd1000, 16'd32767};
    logic [W*ACC_W-1:0] row;
    logic [TILE_W-1:0] exp_t;
    for (int j = 0; j < W; j++) row[j*ACC_W +: ACC_W] = vals[j];
    exp_t = {W{16'hFE40}};
    wr_ready = 1'b0;
    do_start(3'd1, 5'd1);
    for (int r = 0; r < W; r++) drive_row(row);
    total_cnt++;
    if (wr_valid !== 1'b1) $display("FAIL requant_valid: wr_valid %b required 1", wr_valid);
    else pass_cnt++;
    total_cnt++;
    if (wr_data !== exp_t) $display("FAIL requant_data: got %h required %h", wr_data, exp_t);
    else pass_cnt++;
    wr_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b1) $display("FAIL requant_done: done %b required 1", done);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [TILE_W-1:0] exp_t;
    exp_t = lane0_tile(2'd2);
    wr_ready = 1'b1;
    do_start(3'd1, 5'd1);
    send_rows(16'd128, W - 1);
    total_cnt++;
    if (wr_valid !== 1'b0) $display("FAIL single_early_valid: wr_valid %b required 0", wr_valid);
    else pass_cnt++;
    send_rows(16'd128, 1);
    total_cnt++;
    if ({wr_valid, in_ready} !== 2'b10) $display("FAIL single_valid: {wr_valid,in_ready} %b required 10", {wr_valid, in_ready});
    else pass_cnt++;
    total_cnt++;
    if (wr_addr !== 8'd0) $display("FAIL single_addr: got %0d required 0", wr_addr);
    else pass_cnt++;
    total_cnt++;
    if (wr_data !== exp_t) $display("FAIL single_data: got %h required %h", wr_data, exp_t);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({done, wr_valid, busy} !== 3'b101) $display("FAIL single_done: {done,wr_valid,busy} %b required 101", {done, wr_valid, busy});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({done, busy} !== 2'b00) $display("FAIL single_idle: {done,busy} %b required 00", {done, busy});
    else pass_cnt++;
  endtask

  task automatic test_multi();
    wr_ready = 1'b1;
    do_start(3'd2, 5'd2);
    for (int t = 0; t < 8; t++) begin
      send_rows(ACC_W'(64 * (t % 4)), W);
      total_cnt++;
      if ({wr_valid, wr_addr} !== {1'b1, ADDR_W'(t)}) $display("FAIL multi_addr t%0d: valid/addr %b/%0d required 1/%0d", t, wr_valid, wr_addr, t);
      else pass_cnt++;
      total_cnt++;
      if (wr_data !== lane0_tile(N'(t % 4))) $display("FAIL multi_data t%0d: got %h required %h", t, wr_data, lane0_tile(N'(t % 4)));
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (done !== (t == 7)) $display("FAIL multi_done t%0d: done %b required %b", t, done, (t == 7));
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if ({done, busy} !== 2'b00) $display("FAIL multi_idle: {done,busy} %b required 00", {done, busy});
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [TILE_W-1:0] exp0;
    logic [TILE_W-1:0] exp1;
    exp0 = lane0_tile(2'd2);
    exp1 = lane0_tile(2'd1);
    exp1[1:0] = 2'd3;
    wr_ready = 1'b0;
    do_start(3'd1, 5'd2);
    send_rows(16'd130, W);
    in_valid = 1'b1;
    in_row = mk_row(16'd200);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({wr_valid, in_ready, wr_addr, wr_data} !== {1'b1, 1'b0, 8'd0, exp0})
        $display("FAIL bp_hold c%0d: valid %b ready %b addr %0d data %h required 1 0 0 %h", i, wr_valid, in_ready, wr_addr, wr_data, exp0);
      else pass_cnt++;
    end
    wr_ready = 1'b1;
    @(negedge clk);
    wr_ready = 1'b0;
    total_cnt++;
    if ({wr_valid, in_ready, done} !== 3'b010) $display("FAIL bp_release: {valid,ready,done} %b required 010", {wr_valid, in_ready, done});
    else pass_cnt++;
    drive_row(mk_row(16'd200));
    send_rows(16'd64, W - 1);
    total_cnt++;
    if ({wr_valid, wr_addr} !== {1'b1, 8'd1}) $display("FAIL bp_addr1: valid/addr %b/%0d required 1/1", wr_valid, wr_addr);
    else pass_cnt++;
    total_cnt++;
    if (wr_data !== exp1) $display("FAIL bp_data1: got %h required %h", wr_data, exp1);
    else pass_cnt++;
    wr_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b1) $display("FAIL bp_done: done %b required 1", done);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    wr_ready = 1'b1;
    do_start(3'd2, 5'd1);
    send_rows(16'd192, W);
    @(negedge clk);
    send_rows(16'd64, 5);
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({in_ready, wr_valid, busy, done} !== 4'b0000) $display("FAIL rstmid_ctrl: got %b required 0000", {in_ready, wr_valid, busy, done});
    else pass_cnt++;
    total_cnt++;
    if ({wr_addr, wr_data} !== '0) $display("FAIL rstmid_data: addr %0d data %h required 0 0", wr_addr, wr_data);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(3'd2, 5'd1);
    send_rows(16'd64, W);
    total_cnt++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b1, 8'd0, lane0_tile(2'd1)}) $display("FAIL rstmid_restart: valid %b addr %0d data %h", wr_valid, wr_addr, wr_data);
    else pass_cnt++;
    for (int t = 1; t < 4; t++) begin
      @(negedge clk);
      send_rows(16'd64, W);
      total_cnt++;
      if (wr_addr !== ADDR_W'(t)) $display("FAIL rstmid_addr t%0d: got %0d required %0d", t, wr_addr, t);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b1) $display("FAIL rstmid_done: done %b required 1", done);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    wr_ready = 1'b1;
    do_start(3'd2, 5'd1);
    send_rows(16'd64, 3);
    do_start(3'd1, 5'd1);
    send_rows(16'd64, W - 3);
    total_cnt++;
    if ({wr_valid, wr_addr} !== {1'b1, 8'd0}) $display("FAIL ign_addr0: valid/addr %b/%0d required 1/0", wr_valid, wr_addr);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({done, busy, in_ready} !== 3'b011) $display("FAIL ign_continue: {done,busy,ready} %b required 011", {done, busy, in_ready});
    else pass_cnt++;
    for (int t = 1; t < 4; t++) begin
      send_rows(16'd128, W);
      total_cnt++;
      if (wr_addr !== ADDR_W'(t)) $display("FAIL ign_addr t%0d: got %0d required %0d", t, wr_addr, t);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (done !== (t == 3)) $display("FAIL ign_done t%0d: done %b required %b", t, done, (t == 3));
      else pass_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    cfg_tile = '0;
    cfg_tilec = '0;
    in_valid = 1'b0;
    in_row = '0;
    wr_ready = 1'b1;
    #1 rst = 1'b1;
    test_reset();
    test_requant();
    test_single();
    test_multi();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
